// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master issues a request; the slave returns the busy/done status and the result.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract: one full adder and a carry flop.
// Produces one result bit per clock, LSB first.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             reset,
    serial_add_sub_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_ext;

    assign s_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign c_next  = (a_sr_q[0] & b_sr_q[0]) |
                     (a_sr_q[0] & carry_q)   |
                     (b_sr_q[0] & carry_q);
    // New bit enters at the top; the full word is complete on the last bit.
    assign res_ext = {s_bit, res_q};

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? ~bus.cin : bus.cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = res_ext[WIDTH-1:1];
                carry_d = c_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = res_ext;
                    cout_d  = c_next;
                    // carry_q is the carry into the MSB here
                    ovf_d   = carry_q ^ c_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and random checks of serial_add_sub against an
// arithmetic reference model.
module tb_serial_add_sub;
    localparam int W = 8;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    serial_add_sub_if #(.WIDTH(W)) bus ();

    serial_add_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic s, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic ci,
                         output logic [W-1:0] es, output logic ec,
                         output logic eo);
        int r;
        if (!s) begin
            r  = int'(av) + int'(bv) + int'(ci);
            es = r[W-1:0];
            ec = r[W];
            eo = (av[W-1] == bv[W-1]) && (es[W-1] != av[W-1]);
        end else begin
            r  = int'(av) - int'(bv) - int'(ci);
            es = r[W-1:0];
            ec = int'(av) >= (int'(bv) + int'(ci));
            eo = (av[W-1] != bv[W-1]) && (es[W-1] != av[W-1]);
        end
    endtask

    // poke: edge index after acceptance at which a stray start is driven
    task automatic run_op(input logic s, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic ci,
                          input int poke);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        model(s, av, bv, ci, es, ec, eo);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = s;
        bus.a     = av;
        bus.b     = bv;
        bus.cin   = ci;
        @(posedge clk);
        #1;
        chk("busy_accept", 32'(bus.busy), 32'd1);
        for (int e = 1; e <= W; e++) begin
            @(negedge clk);
            bus.start = (e == poke);
            bus.sub   = 1'($urandom);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.cin   = 1'($urandom);
            @(posedge clk);
            #1;
            if (e < W) begin
                chk("busy_mid", 32'(bus.busy), 32'd1);
                chk("done_early", 32'(bus.done), 32'd0);
                chk("sum_hold", 32'(bus.sum), 32'(prev_sum));
                chk("cout_hold", 32'(bus.cout), 32'(prev_cout));
            end else begin
                chk("done", 32'(bus.done), 32'd1);
                chk("busy_end", 32'(bus.busy), 32'd0);
                chk("sum", 32'(bus.sum), 32'(es));
                chk("cout", 32'(bus.cout), 32'(ec));
                chk("ovf", 32'(bus.overflow), 32'(eo));
            end
        end
        // start presented while in DONE must be dropped
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(bus.done), 32'd0);
        chk("busy_in_done", 32'(bus.busy), 32'd0);
        chk("sum_kept", 32'(bus.sum), 32'(es));
        @(negedge clk);
        bus.start = 1'b0;
        prev_sum  = es;
        prev_cout = ec;
        prev_ovf  = eo;
    endtask

    initial begin
        int dn;
        total     = 0;
        bad       = 0;
        prev_sum  = '0;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);

        run_op(1'b0, 8'h3C, 8'h55, 1'b0, 0);
        run_op(1'b0, 8'hFF, 8'h01, 1'b1, 0);
        for (int t = 0; t < 8; t++)
            run_op(1'b0, W'(t[2]), W'(t[1]), t[0], 0);
        run_op(1'b1, 8'h05, 8'h07, 1'b0, 0);
        run_op(1'b1, 8'h80, 8'h01, 1'b0, 0);
        run_op(1'b0, 8'h7F, 8'h01, 1'b0, 3);
        run_op(1'b1, 8'h00, 8'h00, 1'b1, 0);
        run_op(1'b1, 8'h7F, 8'hFF, 1'b0, 0);

        // reset in the middle of an operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.sub   = 1'b0;
        bus.a     = 8'hF0;
        bus.b     = 8'h33;
        bus.cin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        chk("abort_ovf", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        prev_sum  = '0;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;
        run_op(1'b0, 8'h10, 8'h20, 1'b0, 0);

        for (int n = 0; n < 40; n++)
            run_op(1'($urandom), W'($urandom), W'($urandom),
                   1'($urandom), (n % 5 == 0) ? 2 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
